// File: rtl/signal_conflict_monitor.sv
// ---------------------------------------------------------------------------
// signal_conflict_monitor
//
// Safety monitor placed directly after the traffic controller. It turns the
// eight 2-bit movement codes into one-hot lamp drives and watches every cycle
// for conflicting right-of-way, illegal codes and bad yellow sequencing. Any
// fault latches a fault code and forces all lamps to flash red until an
// operator clear is followed by a sustained all-red input from the controller.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   sig_in[15:0] movement codes, 2 bits each (00 red, 01 yellow, 10 green,
//                11 invalid), order N_fwd, N_left, S_fwd, S_left, E_fwd,
//                E_left, W_fwd, W_left from the LSB up
//   fault_clear  single-cycle operator clear request
//   lamps[23:0]  3 bits per movement, same order as sig_in, {red,yellow,green}
//   fault        high while in FAULT or RECOVER
//   fault_code   0 none, 1 conflict, 2 invalid, 3 skipped yellow, 4 short yellow
// ---------------------------------------------------------------------------
module signal_conflict_monitor #(
    parameter int YEL_MIN    = 2,  // minimum consecutive yellow cycles before red
    parameter int FLASH_HALF = 4,  // cycles per on/off half-period while flashing
    parameter int CLR_HOLD   = 3   // consecutive all-red cycles needed to leave RECOVER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sig_in,
    input  logic        fault_clear,
    output logic [23:0] lamps,
    output logic        fault,
    output logic [2:0]  fault_code
);

    localparam int NUM_MOV = 8;
    localparam int YW      = $clog2(YEL_MIN + 1);
    localparam int FW      = $clog2(FLASH_HALF + 1);
    localparam int HW      = $clog2(CLR_HOLD + 1);

    localparam logic [YW-1:0] YEL_SAT    = YW'(YEL_MIN);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(CLR_HOLD - 1);
    localparam logic [23:0]   ALL_RED    = {NUM_MOV{3'b100}};

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;
    localparam logic [1:0] C_INV = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FAULT,
        ST_RECOVER
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE      = 3'd0,
        FC_CONFLICT  = 3'd1,
        FC_INVALID   = 3'd2,
        FC_SKIP_YEL  = 3'd3,
        FC_SHORT_YEL = 3'd4
    } fcode_t;

    state_t          state;
    state_t          state_d;

    logic [23:0]     run_lamps;     // registered decode shown while in RUN
    logic [15:0]     prev_codes;    // codes accepted on the previous RUN cycle
    logic [YW-1:0]   yel_cnt   [NUM_MOV];
    logic [YW-1:0]   yel_cnt_d [NUM_MOV];
    logic [FW-1:0]   flash_cnt;
    logic            flash_on;      // 1: flashing phase shows red, 0: dark
    logic [HW-1:0]   hold_cnt;

    logic [23:0]     decoded;
    logic [3:0]      grp_active;
    logic            any_conflict;
    logic            any_invalid;
    logic            any_skip;
    logic            any_short;
    fcode_t          det_code;
    logic            recover_done;

    function automatic logic [2:0] decode(input logic [1:0] code);
        case (code)
            C_YEL:   return 3'b010;
            C_GRN:   return 3'b001;
            // Invalid codes always fault, so their decode is never displayed.
            default: return 3'b100;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Combinational checks on the current codes against the previous ones
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch
        // is inferred when a path leaves it unassigned.
        decoded     = '0;
        any_invalid = 1'b0;
        any_skip    = 1'b0;
        any_short   = 1'b0;
        for (int i = 0; i < NUM_MOV; i++) begin
            decoded[3*i +: 3] = decode(sig_in[2*i +: 2]);

            if (sig_in[2*i +: 2] == C_INV)
                any_invalid = 1'b1;

            if (prev_codes[2*i +: 2] == C_GRN && sig_in[2*i +: 2] == C_RED)
                any_skip = 1'b1;

            if (prev_codes[2*i +: 2] == C_YEL && sig_in[2*i +: 2] == C_RED &&
                yel_cnt[i] < YEL_SAT)
                any_short = 1'b1;

            // Counter is zero whenever the previous code was not yellow, so a
            // plain saturating increment tracks the current yellow run length.
            if (sig_in[2*i +: 2] == C_YEL)
                yel_cnt_d[i] = (yel_cnt[i] == YEL_SAT) ? YEL_SAT : yel_cnt[i] + 1'b1;
            else
                yel_cnt_d[i] = '0;
        end
    end

    // A group is active when either of its movements shows anything but red;
    // more than one active group is a right-of-way conflict.
    always_comb begin
        grp_active[0] = (sig_in[1:0]   != C_RED) | (sig_in[5:4]   != C_RED);
        grp_active[1] = (sig_in[3:2]   != C_RED) | (sig_in[7:6]   != C_RED);
        grp_active[2] = (sig_in[9:8]   != C_RED) | (sig_in[13:12] != C_RED);
        grp_active[3] = (sig_in[11:10] != C_RED) | (sig_in[15:14] != C_RED);
        any_conflict  = (grp_active & (grp_active - 4'd1)) != 4'd0;
    end

    // Lowest numbered fault wins when several occur together.
    always_comb begin
        det_code = FC_NONE;
        if (any_conflict)     det_code = FC_CONFLICT;
        else if (any_invalid) det_code = FC_INVALID;
        else if (any_skip)    det_code = FC_SKIP_YEL;
        else if (any_short)   det_code = FC_SHORT_YEL;
    end

    assign recover_done = (state == ST_RECOVER) && (sig_in == '0) &&
                          (hold_cnt == HOLD_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) state <= ST_RUN;
        else       state <= state_d;
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state;
        case (state)
            ST_RUN:     if (det_code != FC_NONE) state_d = ST_FAULT;
            ST_FAULT:   if (fault_clear)         state_d = ST_RECOVER;
            ST_RECOVER: if (recover_done)        state_d = ST_RUN;
            default:                             state_d = ST_RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        lamps = ALL_RED;
        fault = 1'b1;
        if (state == ST_RUN) begin
            lamps = run_lamps;
            fault = 1'b0;
        end else if (!flash_on) begin
            lamps = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            run_lamps  <= ALL_RED;
            fault_code <= FC_NONE;
            prev_codes <= '0;
            // NOTE: the yellow counters are a tiny flop array, not a RAM, so
            // resetting every entry is cheap and required for correct checks.
            for (int i = 0; i < NUM_MOV; i++) yel_cnt[i] <= '0;
            flash_cnt  <= '0;
            flash_on   <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (det_code != FC_NONE) begin
                        fault_code <= det_code;
                        flash_cnt  <= '0;
                        flash_on   <= 1'b1;
                        hold_cnt   <= '0;
                    end else begin
                        run_lamps  <= decoded;
                        prev_codes <= sig_in;
                        for (int i = 0; i < NUM_MOV; i++) yel_cnt[i] <= yel_cnt_d[i];
                    end
                end
                default: begin
                    // Flashing runs through both FAULT and RECOVER.
                    if (flash_cnt == FLASH_LAST) begin
                        flash_cnt <= '0;
                        flash_on  <= ~flash_on;
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end

                    if (recover_done) begin
                        // Resume as if the controller had shown all red forever.
                        hold_cnt   <= '0;
                        fault_code <= FC_NONE;
                        prev_codes <= '0;
                        run_lamps  <= ALL_RED;
                        for (int i = 0; i < NUM_MOV; i++) yel_cnt[i] <= '0;
                    end else if (state == ST_RECOVER && sig_in == '0) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        hold_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
